// File: rtl/mico8_intc_pkg.sv
// Shared definitions for the Mico8 interrupt controller: register map, FSM encoding,
// ACTIVE register layout and the priority encoder used to pick the serviced source.
package mico8_intc_pkg;

  localparam logic [7:0] INTC_PENDING = 8'd0;
  localparam logic [7:0] INTC_MASK    = 8'd1;
  localparam logic [7:0] INTC_EDGE    = 8'd2;
  localparam logic [7:0] INTC_ACTIVE  = 8'd3;
  localparam logic [7:0] INTC_SWI     = 8'd4;

  localparam int ACTIVE_VLD_BIT = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_e;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/mico8_intc_sync_edge.sv
// Per-vector 2-flop synchroniser plus rising-edge detect for asynchronous requests.
// Latency: level and rise valid 2 clocks after the input; no backpressure.
// Backpressure: none, free-running sampler.
module mico8_intc_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] lvl,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1_q, s2_q, s3_q;
  logic [W-1:0] s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/mico8_intr_ctrl.sv
// Multi-source interrupt controller for Mico8 (optional SWI register via MICO8_INTC_SWI_EN).
// Latency: irq_in to pending 3 clocks, pending to intr 1 clock; io_ready 1 clock after strobe.
// Backpressure: strobe held until io_ready; a held strobe must drop before the next transfer.
module mico8_intr_ctrl
  import mico8_intc_pkg::*;
#(
  parameter int         NUM_IRQ   = 8,
  parameter logic [7:0] BASE_ADDR = 8'hF0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [7:0]         io_addr,
  input  logic [7:0]         io_wdata,
  input  logic               io_rd,
  input  logic               io_wr,
  output logic [7:0]         io_rdata,
  output logic               io_ready,
  output logic               intr,
  input  logic               intr_ack,
  output logic [2:0]         irq_active
);

  localparam logic [7:0] VMASK = 8'((16'd1 << NUM_IRQ) - 16'd1);

  logic [NUM_IRQ-1:0] sync_lvl, sync_rise;
  logic [7:0] lvl8, rise8;

  mico8_intc_sync_edge #(.W(NUM_IRQ)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (irq_in),
    .lvl      (sync_lvl),
    .rise     (sync_rise)
  );

  assign lvl8  = 8'(sync_lvl);
  assign rise8 = 8'(sync_rise);

  logic [7:0] pending_q, pending_d, mask_q, mask_d, edge_q, edge_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rdy_q, rdy_d, busy_q, busy_d;
  logic [7:0] off, w1c, swi, act_reg, req_vec;
  logic       strobe, hit, xfer, wr, rd;

  intc_state_e state_q;
  logic        intr_q, valid_q, ack_q;
  logic [2:0]  active_q;

  assign strobe = io_rd | io_wr;
  assign off    = io_addr - BASE_ADDR;
`ifdef MICO8_INTC_SWI_EN
  assign hit    = strobe && (off <= INTC_SWI);
`else
  assign hit    = strobe && (off <= INTC_ACTIVE);
`endif
  // busy_q blocks a second transfer until the strobe has been seen low.
  assign xfer   = hit & ~busy_q;
  assign wr     = xfer & io_wr;
  assign rd     = xfer & io_rd;

  always_comb begin
    act_reg                 = 8'h00;
    act_reg[ACTIVE_VLD_BIT] = valid_q;
    act_reg[2:0]            = active_q;
  end

  always_comb begin
    mask_d  = mask_q;
    edge_d  = edge_q;
    w1c     = 8'h00;
    swi     = 8'h00;
    rdata_d = 8'h00;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    if (wr) begin
      case (off)
        INTC_PENDING: w1c    = io_wdata;
        INTC_MASK:    mask_d = io_wdata & VMASK;
        INTC_EDGE:    edge_d = io_wdata & VMASK;
`ifdef MICO8_INTC_SWI_EN
        INTC_SWI:     swi    = io_wdata & VMASK;
`endif
        default: ;
      endcase
    end
    if (rd) begin
      case (off)
        INTC_PENDING: rdata_d = pending_q;
        INTC_MASK:    rdata_d = mask_q;
        INTC_EDGE:    rdata_d = edge_q;
        INTC_ACTIVE:  rdata_d = act_reg;
        default:      rdata_d = 8'h00;
      endcase
    end
    if (xfer) begin
      rdy_d  = 1'b1;
      busy_d = 1'b1;
    end else if (!strobe) begin
      busy_d = 1'b0;
    end
    // Edge bits: a fresh edge beats a same-cycle W1C. Level bits track the input.
    pending_d = ((edge_q & ((pending_q & ~w1c) | rise8)) | (~edge_q & lvl8) | swi) & VMASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 8'h00;
      mask_q    <= 8'h00;
      edge_q    <= VMASK;
      rdata_q   <= 8'h00;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      rdata_q   <= rdata_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign req_vec = pending_q & mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      intr_q   <= 1'b0;
      active_q <= 3'd0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= intr_ack;
      case (state_q)
        IDLE: begin
          // An ack arriving here was sampled late by the core: spurious.
          if (intr_ack && !ack_q) begin
            state_q <= SERVICE;
            valid_q <= 1'b0;
          end else if (|req_vec) begin
            state_q <= REQ;
            intr_q  <= 1'b1;
          end
        end
        REQ: begin
          if (intr_ack && !ack_q) begin
            state_q  <= SERVICE;
            intr_q   <= 1'b0;
            active_q <= lowest_idx(req_vec);
            valid_q  <= |req_vec;
          end else if (req_vec == 8'h00) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
          end
        end
        SERVICE: begin
          if (!intr_ack && ack_q) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign io_rdata   = rdata_q;
  assign io_ready   = rdy_q;
  assign intr       = intr_q;
  assign irq_active = active_q;

endmodule

// File: tb/tb_mico8_intr_ctrl.sv
// Bench for mico8_intr_ctrl: register table plus hand-written interrupt sequences.
module tb_mico8_intr_ctrl;

  localparam logic [7:0] BASE = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic [7:0] io_addr = 8'h00, io_wdata = 8'h00;
  logic       io_rd = 1'b0, io_wr = 1'b0;
  logic [7:0] io_rdata;
  logic       io_ready, intr, intr_ack = 1'b0;
  logic [2:0] irq_active;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mico8_intr_ctrl #(.NUM_IRQ(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rd(io_rd), .io_wr(io_wr),
    .io_rdata(io_rdata), .io_ready(io_ready),
    .intr(intr), .intr_ack(intr_ack), .irq_active(irq_active)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       hit;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus transfer; expected read data is queued when the strobe is driven.
  task automatic bus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic hit, input logic [7:0] rd, input string nm);
    logic got_rdy;
    logic [7:0] rd_seen;
    got_rdy = 1'b0;
    rd_seen = 8'h00;
    io_addr = addr;
    io_wdata = wdata;
    io_wr = wr;
    io_rd = ~wr;
    if (!wr && hit) exp_q.push_back(rd);
    for (int i = 0; i < 4 && !got_rdy; i++) begin
      tick();
      if (io_ready) begin
        got_rdy = 1'b1;
        rd_seen = io_rdata;
      end else if (io_rdata !== 8'h00) begin
        rd_seen = io_rdata;
      end
    end
    chk({nm, ".ready"}, {7'd0, got_rdy}, {7'd0, hit});
    if (!wr && hit) begin
      if (got_rdy) chk({nm, ".rdata"}, rd_seen, exp_q.pop_front());
      else void'(exp_q.pop_front());
    end else if (!hit) begin
      chk({nm, ".rdata_idle"}, rd_seen, 8'h00);
    end
    io_rd = 1'b0;
    io_wr = 1'b0;
    tick();
  endtask

  task automatic rd_reg(input logic [7:0] off, input logic [7:0] want, input string nm);
    bus(1'b0, BASE + off, 8'h00, 1'b1, want, nm);
  endtask

  task automatic wr_reg(input logic [7:0] off, input logic [7:0] d, input string nm);
    bus(1'b1, BASE + off, d, 1'b1, 8'h00, nm);
  endtask

  task automatic wait_intr(input logic want, input int budget, input string nm);
    int n;
    n = 0;
    while (intr !== want && n < budget) begin
      tick();
      n++;
    end
    chk(nm, {7'd0, intr}, {7'd0, want});
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    irq_in = bits;
    tick();
    irq_in = 8'h00;
  endtask

  task automatic ack_set(input logic v);
    intr_ack = v;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt;

    tbl.push_back('{1'b0, BASE + 8'd0, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b0, BASE + 8'd1, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b0, BASE + 8'd2, 8'h00, 1'b1, 8'hFF});
    tbl.push_back('{1'b0, BASE + 8'd3, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b1, BASE + 8'd1, 8'hA5, 1'b1, 8'h00});
    tbl.push_back('{1'b0, BASE + 8'd1, 8'h00, 1'b1, 8'hA5});
    tbl.push_back('{1'b1, BASE + 8'd2, 8'h3C, 1'b1, 8'h00});
    tbl.push_back('{1'b0, BASE + 8'd2, 8'h00, 1'b1, 8'h3C});
    tbl.push_back('{1'b1, BASE + 8'd3, 8'h55, 1'b1, 8'h00});
    tbl.push_back('{1'b0, BASE + 8'd3, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b0, BASE - 8'd1, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{1'b0, BASE + 8'd5, 8'h00, 1'b0, 8'h00});
`ifdef MICO8_INTC_SWI_EN
    tbl.push_back('{1'b0, BASE + 8'd4, 8'h00, 1'b1, 8'h00});
`else
    tbl.push_back('{1'b0, BASE + 8'd4, 8'h00, 1'b0, 8'h00});
`endif
    tbl.push_back('{1'b1, BASE + 8'd1, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b1, BASE + 8'd2, 8'hFF, 1'b1, 8'h00});

    #1;
    chk("rst.intr", {7'd0, intr}, 8'h00);
    chk("rst.ready", {7'd0, io_ready}, 8'h00);
    chk("rst.rdata", io_rdata, 8'h00);
    chk("rst.active", {5'd0, irq_active}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      bus(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].hit, tbl[i].rd, $sformatf("tbl%0d", i));
    end

    // Single edge source through a full ISR.
    wr_reg(8'd1, 8'h01, "t1.mask");
    pulse_irq(8'h01);
    wait_intr(1'b1, 4, "t1.intr_up");
    rd_reg(8'd0, 8'h01, "t1.pend");
    ack_set(1'b1);
    chk("t1.intr_ack", {7'd0, intr}, 8'h00);
    rd_reg(8'd3, 8'h80, "t1.active");
    ack_set(1'b0);
    rd_reg(8'd0, 8'h01, "t1.pend_after");
    wr_reg(8'd0, 8'h01, "t1.w1c");
    rd_reg(8'd0, 8'h00, "t1.pend_clr");
    wait_intr(1'b0, 4, "t1.intr_down");

    // Two simultaneous sources: priority to the lower index.
    wr_reg(8'd1, 8'hFF, "t2.mask");
    pulse_irq(8'h24);
    wait_intr(1'b1, 6, "t2.intr_up");
    ack_set(1'b1);
    rd_reg(8'd3, 8'h82, "t2.active2");
    chk("t2.irq_active", {5'd0, irq_active}, 8'h02);
    wr_reg(8'd0, 8'h04, "t2.w1c2");
    chk("t2.intr_svc", {7'd0, intr}, 8'h00);
    ack_set(1'b0);
    wait_intr(1'b1, 3, "t2.intr_again");
    ack_set(1'b1);
    rd_reg(8'd3, 8'h85, "t2.active5");
    ack_set(1'b0);
    wr_reg(8'd0, 8'h20, "t2.w1c5");
    wait_intr(1'b0, 4, "t2.intr_down");
    wr_reg(8'd1, 8'h00, "t2.mask0");

    // Level mode: W1C has no effect, pending follows the input.
    wr_reg(8'd2, 8'h00, "t3.edge");
    wr_reg(8'd1, 8'h08, "t3.mask");
    irq_in = 8'h08;
    repeat (4) tick();
    wr_reg(8'd0, 8'h08, "t3.w1c");
    rd_reg(8'd0, 8'h08, "t3.pend_held");
    irq_in = 8'h00;
    repeat (4) tick();
    rd_reg(8'd0, 8'h00, "t3.pend_drop");
    wait_intr(1'b0, 4, "t3.intr_down");
    wr_reg(8'd2, 8'hFF, "t3.edge_back");
    wr_reg(8'd1, 8'h00, "t3.mask0");

    // New edge lands on the same edge as a W1C of that bit.
    pulse_irq(8'h02);
    repeat (3) tick();
    rd_reg(8'd0, 8'h02, "t4.pend_pre");
    irq_in = 8'h02;
    tick();
    tick();
    wr_reg(8'd0, 8'h02, "t4.w1c_race");
    rd_reg(8'd0, 8'h02, "t4.set_wins");
    irq_in = 8'h00;
    wr_reg(8'd0, 8'h02, "t4.w1c");
    rd_reg(8'd0, 8'h00, "t4.pend_clr");

    // Held read strobe produces a single ready pulse.
    wr_reg(8'd1, 8'h5A, "t5.mask");
    io_addr = BASE + 8'd1;
    io_rd = 1'b1;
    exp_q.push_back(8'h5A);
    rdy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (io_ready) begin
        rdy_cnt++;
        chk("t5.held_rdata", io_rdata, exp_q.pop_front());
      end
    end
    io_rd = 1'b0;
    tick();
    chk("t5.ready_cnt", 8'(rdy_cnt), 8'd1);
    if (exp_q.size() != 0) exp_q.delete();
    wr_reg(8'd1, 8'h00, "t5.mask0");

    // Reset during SERVICE.
    wr_reg(8'd1, 8'h01, "t6.mask");
    pulse_irq(8'h01);
    wait_intr(1'b1, 6, "t6.intr_up");
    ack_set(1'b1);
    ack_set(1'b0);
    wait_intr(1'b1, 3, "t6.intr_up2");
    intr_ack = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6.rst_intr", {7'd0, intr}, 8'h00);
    chk("t6.rst_active", {5'd0, irq_active}, 8'h00);
    intr_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd_reg(8'd1, 8'h00, "t6.mask_rst");
    rd_reg(8'd3, 8'h00, "t6.active_rst");
    rd_reg(8'd0, 8'h00, "t6.pend_rst");
`ifdef MICO8_INTC_SWI_EN
    wr_reg(8'd4, 8'h10, "t6.swi");
    wr_reg(8'd1, 8'h10, "t6.swi_mask");
    wait_intr(1'b1, 4, "t6.swi_intr");
    ack_set(1'b1);
    rd_reg(8'd3, 8'h84, "t6.swi_active");
    ack_set(1'b0);
    wr_reg(8'd0, 8'h10, "t6.swi_w1c");
    wait_intr(1'b0, 4, "t6.swi_down");
`else
    bus(1'b1, BASE + 8'd4, 8'h10, 1'b0, 8'h00, "t6.swi_unmapped");
    wr_reg(8'd1, 8'h10, "t6.swi_mask");
    repeat (3) tick();
    rd_reg(8'd0, 8'h00, "t6.swi_noeffect");
    chk("t6.swi_nointr", {7'd0, intr}, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
